coram_fill_userlogic: RTL and testbench
=======================================

# coram_fill_userlogic

Producer-side user logic for the CoRAM sample apps: the write-side counterpart of the sum reader. On a two-word command (seed, stride) from the control thread over a CoramChannel, it fills a CoramMemory1P with the arithmetic sequence seed + i·stride. It then returns the wrapped sum of the written words as a completion token, so the control thread can DMA the buffer out and check it.

## Interface
- W_A, 7: memory address width.
- W_COMM_A, 4: channel FIFO address width.
- W_D, 32: data width of the memory, the channel and the arithmetic.
- SIZE, 128: words written per command; must equal 2^W_A or be smaller.
- THREAD_NAME, "ctrl_thread": CORAM_THREAD_NAME passed to both instances.

- CLK  in  1  sole clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- busy  out  1  high from the first command DEQ until the completion ENQ.
- checksum  out  W_D  last completion token sent; holds between commands.
- block_count  out  16  count of completed commands; wraps at 2^16.

Internal instances:
- CoramMemory1P: CORAM_ID 0, SUB_ID 0, ADDR_LEN W_A, DATA_WIDTH W_D.
- CoramChannel: CORAM_ID 0, ADDR_LEN W_COMM_A, DATA_WIDTH W_D.
- Both instances take CLK. The channel's active-high RST is driven by !RST_N.

## Operation
- Channel read rule: a 1-cycle DEQ pulse is issued only when EMPTY=0. The popped word is valid on Q in the following cycle and is captured in that cycle.
- Command format: word 0 is seed, word 1 is stride, both W_D bits.
- FSM states and transitions:
  - IDLE: wait for !EMPTY, pulse DEQ, go to SEED. busy=0.
  - SEED: capture Q into val, clear acc, go to STR_REQ.
  - STR_REQ: wait for !EMPTY, pulse DEQ, go to STR.
  - STR: capture Q into stride, clear addr, go to WRITE.
  - WRITE: drive WE=1, ADDR=addr, D=val. Then acc += val, val += stride, addr += 1.
    - All arithmetic is mod 2^W_D; wrap is silent.
    - After the write at addr = SIZE-1, go to REPORT.
  - REPORT: wait for !FULL. Then D=acc, pulse ENQ for 1 cycle, set checksum=acc, block_count += 1, go to IDLE.
- The memory is write-only from this block. Q of the memory is unused, and WE=0 in every state except WRITE.
- Commands that arrive while busy stay in the channel FIFO. They are dequeued only from IDLE, so no command is lost or merged.
- ENQ and DEQ are never asserted in the same cycle.
- Reset mid-operation:
  - The FSM goes to IDLE and all registers clear.
  - Partially written memory contents are left as they are.
  - No token is sent for the aborted command.
  - Channel contents are owned by the channel's own reset.

## Timing
- Reset values: busy 0, checksum 0, block_count 0, WE 0, ENQ 0, DEQ 0, ADDR 0, D 0, FSM in IDLE.
- All outputs and all memory and channel controls are registered.
- With both command words present (EMPTY=0) and FULL=0, relative to the first DEQ at cycle t:
  - seed DEQ at t, stride DEQ at t+2;
  - WE high for exactly SIZE consecutive cycles, t+4 to t+3+SIZE, ADDR stepping 0..SIZE-1;
  - ENQ at t+4+SIZE; checksum and block_count update in the same cycle.
- The stride word arriving late stretches STR_REQ only. FULL stretches REPORT only. WRITE is never stalled.
- busy rises the cycle after the first DEQ and falls the cycle after ENQ.
- The next command's DEQ can occur at the earliest one cycle after returning to IDLE.

## Test plan
- Seed 0, stride 1, SIZE 128 -> mem[i]=i for i = 0..127; token 8128 (0x1FC0); block_count 1; ENQ exactly SIZE+4 cycles after the first DEQ.
- Seed 0xFFFFFFF0, stride 1 -> mem[15]=0xFFFFFFFF, mem[16]=0 (wrap); token 0x17C0.
- Seed 5, stride 0 -> all 128 words equal 5; token 640. Then seed 3, stride 0xFFFFFFFF -> mem[4]=0xFFFFFFFF (decrement with wrap); block_count 2.
- Hold FULL=1 for 20 cycles at REPORT -> ENQ stays 0 and busy stays 1. ENQ is a single 1-cycle pulse after FULL drops, and D holds the token during that pulse.
- Stride word delayed 10 cycles after the seed -> FSM waits in STR_REQ with WE=0, then completes with the correct data.
- Drop RST_N during WRITE at ADDR 40 -> all outputs return to reset values asynchronously and no ENQ occurs. A fresh command after release completes normally with block_count 1.

Source files
------------

// File: rtl/coram_fill_userlogic.sv
// coram_fill_userlogic: fills a CoRAM memory with seed + i*stride per channel command and returns the wrapped word sum.

// CoramMemory1P: single-port CoRAM buffer, synchronous write, registered read.
module CoramMemory1P #(
    parameter     CORAM_THREAD_NAME = "undefined",
    parameter int CORAM_ID          = 0,
    parameter int CORAM_SUB_ID      = 0,
    parameter int CORAM_ADDR_LEN    = 7,
    parameter int CORAM_DATA_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic [CORAM_ADDR_LEN-1:0]   ADDR,
    input  logic [CORAM_DATA_WIDTH-1:0] D,
    input  logic                        WE,
    output logic [CORAM_DATA_WIDTH-1:0] Q
);
    logic [CORAM_DATA_WIDTH-1:0] mem [2**CORAM_ADDR_LEN];

    // write port and registered read port share the single address
    always_ff @(posedge CLK) begin
        if (WE) mem[ADDR] <= D;
        Q <= mem[ADDR];
    end
endmodule

// CoramChannel: word FIFOs between user logic and the control thread; the sys_* side belongs to the thread.
module CoramChannel #(
    parameter     CORAM_THREAD_NAME = "undefined",
    parameter int CORAM_ID          = 0,
    parameter int CORAM_ADDR_LEN    = 4,
    parameter int CORAM_DATA_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [CORAM_DATA_WIDTH-1:0] D,
    input  logic                        ENQ,
    output logic                        FULL,
    output logic [CORAM_DATA_WIDTH-1:0] Q,
    input  logic                        DEQ,
    output logic                        EMPTY
);
    localparam int AL = CORAM_ADDR_LEN;
    localparam int PW = AL + 1;

    // thread side: idle until the control thread drives it
    logic                        sys_enq  = 1'b0;
    logic [CORAM_DATA_WIDTH-1:0] sys_d    = '0;
    logic                        sys_deq  = 1'b0;
    logic                        sys_hold = 1'b0;
    logic [CORAM_DATA_WIDTH-1:0] sys_q;
    logic                        sys_empty;

    logic [CORAM_DATA_WIDTH-1:0] in_mem  [2**AL];
    logic [CORAM_DATA_WIDTH-1:0] out_mem [2**AL];
    logic [PW-1:0]               in_wr, in_rd, out_wr, out_rd;
    logic                        push_out;

    assign EMPTY     = in_wr == in_rd;
    assign FULL      = sys_hold || (out_wr[AL-1:0] == out_rd[AL-1:0] && out_wr[AL] != out_rd[AL]);
    assign sys_empty = out_wr == out_rd;
    assign sys_q     = out_mem[out_rd[AL-1:0]];
    assign push_out  = ENQ && !FULL;

    // FIFO storage, no reset on the data arrays
    always_ff @(posedge CLK) begin
        if (sys_enq) in_mem[in_wr[AL-1:0]] <= sys_d;
        if (push_out) out_mem[out_wr[AL-1:0]] <= D;
    end

    // pointers and the registered pop data toward user logic
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_wr  <= '0;
            in_rd  <= '0;
            out_wr <= '0;
            out_rd <= '0;
            Q      <= '0;
        end else begin
            if (sys_enq) in_wr <= in_wr + PW'(1);
            if (DEQ && !EMPTY) begin
                Q     <= in_mem[in_rd[AL-1:0]];
                in_rd <= in_rd + PW'(1);
            end
            if (push_out) out_wr <= out_wr + PW'(1);
            if (sys_deq && !sys_empty) out_rd <= out_rd + PW'(1);
        end
    end
endmodule

module coram_fill_userlogic #(
    parameter int W_A         = 7,
    parameter int W_COMM_A    = 4,
    parameter int W_D         = 32,
    parameter int SIZE        = 128,
    parameter     THREAD_NAME = "ctrl_thread"
) (
    input  logic           CLK,
    input  logic           RST_N,
    output logic           busy,
    output logic [W_D-1:0] checksum,
    output logic [15:0]    block_count
);
    typedef enum logic [2:0] {IDLE, SEED, STR_REQ, STR, WRITE, REPORT} state_t;

    state_t         state, state_n;
    logic [W_D-1:0] val, val_n, stride, stride_n, acc, acc_n, step;
    logic [W_A-1:0] addr, addr_n;
    logic           mem_we, mem_we_n;
    logic [W_A-1:0] mem_addr, mem_addr_n;
    logic [W_D-1:0] mem_d, mem_d_n, mem_q_unused;
    logic           ch_enq, ch_enq_n, ch_deq, ch_deq_n, ch_full, ch_empty;
    logic [W_D-1:0] ch_d, ch_d_n, ch_q, checksum_n;
    logic [15:0]    block_count_n;

    CoramMemory1P #(
        .CORAM_THREAD_NAME(THREAD_NAME),
        .CORAM_ID(0),
        .CORAM_SUB_ID(0),
        .CORAM_ADDR_LEN(W_A),
        .CORAM_DATA_WIDTH(W_D)
    ) u_mem (
        .CLK(CLK),
        .ADDR(mem_addr),
        .D(mem_d),
        .WE(mem_we),
        .Q(mem_q_unused)
    );

    CoramChannel #(
        .CORAM_THREAD_NAME(THREAD_NAME),
        .CORAM_ID(0),
        .CORAM_ADDR_LEN(W_COMM_A),
        .CORAM_DATA_WIDTH(W_D)
    ) u_chan (
        .CLK(CLK),
        .RST(!RST_N),
        .D(ch_d),
        .ENQ(ch_enq),
        .FULL(ch_full),
        .Q(ch_q),
        .DEQ(ch_deq),
        .EMPTY(ch_empty)
    );

    // the stride pop lands on Q during the first write, so use it directly there
    assign step = (addr == '0) ? ch_q : stride;

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    // next state and next values of every registered control
    always_comb begin
        state_n       = state;
        val_n         = val;
        stride_n      = stride;
        acc_n         = acc;
        addr_n        = addr;
        mem_we_n      = 1'b0;
        mem_addr_n    = mem_addr;
        mem_d_n       = mem_d;
        ch_enq_n      = 1'b0;
        ch_deq_n      = 1'b0;
        ch_d_n        = ch_d;
        checksum_n    = checksum;
        block_count_n = block_count;
        case (state)
            IDLE: begin
                ch_deq_n = !ch_empty;
                state_n  = ch_empty ? IDLE : SEED;
            end
            SEED: begin
                acc_n   = '0;
                state_n = STR_REQ;
            end
            STR_REQ: begin
                val_n    = ch_q;
                ch_deq_n = !ch_empty;
                state_n  = ch_empty ? STR_REQ : STR;
            end
            STR: begin
                addr_n  = '0;
                state_n = WRITE;
            end
            WRITE: begin
                mem_we_n   = 1'b1;
                mem_addr_n = addr;
                mem_d_n    = val;
                stride_n   = step;
                acc_n      = acc + val;
                val_n      = val + step;
                addr_n     = addr + W_A'(1);
                state_n    = (addr == W_A'(SIZE - 1)) ? REPORT : WRITE;
            end
            REPORT: begin
                if (!ch_full) begin
                    ch_enq_n      = 1'b1;
                    ch_d_n        = acc;
                    checksum_n    = acc;
                    block_count_n = block_count + 16'd1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            val         <= '0;
            stride      <= '0;
            acc         <= '0;
            addr        <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_d       <= '0;
            ch_enq      <= 1'b0;
            ch_deq      <= 1'b0;
            ch_d        <= '0;
            busy        <= 1'b0;
            checksum    <= '0;
            block_count <= '0;
        end else begin
            val         <= val_n;
            stride      <= stride_n;
            acc         <= acc_n;
            addr        <= addr_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_d       <= mem_d_n;
            ch_enq      <= ch_enq_n;
            ch_deq      <= ch_deq_n;
            ch_d        <= ch_d_n;
            busy        <= state != IDLE;
            checksum    <= checksum_n;
            block_count <= block_count_n;
        end
    end
endmodule

// File: tb/tb_coram_fill_userlogic.sv
// tb_coram_fill_userlogic: directed commands through the channel, scoreboard monitor on completion tokens.
module tb_coram_fill_userlogic;
    localparam int SIZE = 128;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        busy;
    logic [31:0] checksum;
    logic [15:0] block_count;

    int   checks = 0, errors = 0, cyc = 0, deq_cyc = 0, we_cnt = 0, step_err = 0;
    logic enq_prev = 1'b0;

    typedef struct {
        logic [31:0] tok;
        logic [15:0] cnt;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    coram_fill_userlogic #(
        .W_A(7), .W_COMM_A(4), .W_D(32), .SIZE(SIZE), .THREAD_NAME("ctrl_thread")
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .busy(busy),
        .checksum(checksum),
        .block_count(block_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [31:0] v);
        dut.u_chan.sys_d   = v;
        dut.u_chan.sys_enq = 1'b1;
        @(negedge CLK);
        dut.u_chan.sys_enq = 1'b0;
    endtask

    task automatic cmd(input logic [31:0] seed, input logic [31:0] stride,
                       input logic [31:0] tok, input logic [15:0] cnt, input int lat);
        exp_q.push_back('{tok, cnt, lat});
        push(seed);
        push(stride);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_done"}, 64'(exp_q.size()), 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_mem(input string nm, input logic [31:0] seed, input logic [31:0] stride);
        int bad = 0;
        for (int i = 0; i < SIZE; i++) begin
            logic [31:0] e;
            e = seed + 32'(i) * stride;
            if (dut.u_mem.mem[i] !== e) bad++;
        end
        chk({nm, "_mem"}, 64'(bad), 0);
    endtask

    // monitor: tracks write bursts and checks every completion token against the scoreboard
    always @(negedge CLK) begin
        exp_t e;
        dut.u_chan.sys_deq = !dut.u_chan.sys_empty;
        if (!RST_N) begin
            we_cnt   = 0;
            step_err = 0;
            enq_prev = 1'b0;
        end else begin
            if (dut.ch_deq && !busy) begin
                deq_cyc  = cyc;
                we_cnt   = 0;
                step_err = 0;
            end
            if (dut.mem_we) begin
                if (dut.mem_addr != 7'(we_cnt)) step_err++;
                we_cnt++;
            end
            if (dut.ch_enq) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_enq", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("token_d", dut.ch_d, e.tok);
                    chk("checksum", checksum, e.tok);
                    chk("block_count", block_count, e.cnt);
                    chk("we_cycles", 64'(we_cnt), SIZE);
                    chk("addr_step", 64'(step_err), 0);
                    chk("enq_single", enq_prev, 0);
                    chk("enq_deq_overlap", dut.ch_deq, 0);
                    if (e.lat != 0) chk("enq_latency", 64'(cyc - deq_cyc), 64'(e.lat));
                end
            end
            enq_prev = dut.ch_enq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, bad;
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_block_count", block_count, 0);
        chk("rst_ctrl", {dut.mem_we, dut.ch_enq, dut.ch_deq}, 0);
        chk("rst_addr_d", {dut.mem_addr, dut.mem_d, dut.ch_d}, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        cmd(32'd0, 32'd1, 32'h1FC0, 16'd1, SIZE + 4);
        drain("ramp");
        check_mem("ramp", 32'd0, 32'd1);
        chk("ramp_mem127", dut.u_mem.mem[127], 127);
        chk("busy_after", busy, 0);

        cmd(32'hFFFF_FFF0, 32'd1, 32'h17C0, 16'd2, SIZE + 4);
        drain("wrap");
        chk("wrap_mem15", dut.u_mem.mem[15], 32'hFFFF_FFFF);
        chk("wrap_mem16", dut.u_mem.mem[16], 0);
        check_mem("wrap", 32'hFFFF_FFF0, 32'd1);

        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        cmd(32'd5, 32'd0, 32'd640, 16'd1, SIZE + 4);
        drain("const");
        check_mem("const", 32'd5, 32'd0);
        cmd(32'd3, 32'hFFFF_FFFF, 32'hFFFF_E1C0, 16'd2, SIZE + 4);
        drain("down");
        chk("down_mem4", dut.u_mem.mem[4], 32'hFFFF_FFFF);
        check_mem("down", 32'd3, 32'hFFFF_FFFF);

        cmd(32'd7, 32'd3, 32'h62C0, 16'd3, 0);
        dut.u_chan.sys_hold = 1'b1;
        n = 0;
        while (!dut.mem_we && n < 50) begin @(negedge CLK); n++; end
        while (dut.mem_we && n < 400) begin @(negedge CLK); n++; end
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (dut.ch_enq || !busy) bad++;
        end
        chk("full_stall", 64'(bad), 0);
        dut.u_chan.sys_hold = 1'b0;
        drain("full");
        check_mem("full", 32'd7, 32'd3);

        exp_q.push_back('{32'h7180, 16'd4, 0});
        push(32'd100);
        repeat (4) @(negedge CLK);
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (dut.mem_we || !busy) bad++;
        end
        chk("stride_wait", 64'(bad), 0);
        push(32'd2);
        drain("late");
        check_mem("late", 32'd100, 32'd2);

        push(32'h1000);
        push(32'd1);
        n = 0;
        while (!(dut.mem_we && dut.mem_addr == 7'd40) && n < 300) begin @(negedge CLK); n++; end
        chk("abort_reached", dut.mem_addr, 40);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_checksum", checksum, 0);
        chk("abort_block_count", block_count, 0);
        chk("abort_ctrl", {dut.mem_we, dut.ch_enq, dut.ch_deq}, 0);
        chk("abort_addr_d", {dut.mem_addr, dut.mem_d, dut.ch_d}, 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("abort_mem39", dut.u_mem.mem[39], 32'h1027);
        chk("abort_mem40", dut.u_mem.mem[40], 180);
        chk("abort_mem41", dut.u_mem.mem[41], 182);

        cmd(32'h10, 32'h10, 32'h0002_0400, 16'd1, SIZE + 4);
        drain("fresh");
        check_mem("fresh", 32'h10, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
